// File: rtl/corr_coeff_loader.sv
// rtl/corr_coeff_loader.sv - packs 9-bit coefficient samples into 36-bit words and writes them to a bank
module corr_coeff_loader #(
    parameter int DW    = 9,
    parameter int LANES = 4,
    parameter int SEQ_W = 6,
    parameter int SEL_W = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   load_start_i,
    input  logic [SEL_W-1:0]       load_bank_i,
    input  logic [SEQ_W:0]         load_len_i,
    input  logic                   load_abort_i,
    input  logic [DW-1:0]          in_data_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [SEL_W+SEQ_W-1:0] coeff_index_o,
    output logic [DW*LANES-1:0]    coeff_value_o,
    output logic                   coeff_write_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                  state_q;
    logic [SEL_W-1:0]        bank_q;
    logic [SEQ_W-1:0]        last_q;
    logic [SEQ_W-1:0]        word_q;
    logic [SEQ_W-1:0]        word_d;
    logic [LW-1:0]           lane_q;
    logic [LW-1:0]           lane_d;
    logic [DW*(LANES-1)-1:0] pack_q;
    logic                    accept;
    logic                    lane_full;

    assign accept    = in_valid_i & in_ready_o;
    assign lane_full = (lane_q == LW'(LANES - 1));
    assign word_d    = word_q + 1'b1;
    assign lane_d    = lane_q + 1'b1;

    // A length of 0 and of 64 both reduce to last word 63 in the low SEQ_W bits.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            bank_q        <= '0;
            last_q        <= '0;
            word_q        <= '0;
            lane_q        <= '0;
            pack_q        <= '0;
            in_ready_o    <= 1'b0;
            coeff_index_o <= '0;
            coeff_value_o <= '0;
            coeff_write_o <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            coeff_write_o <= 1'b0;
            done_o        <= 1'b0;
            if (load_abort_i) begin
                state_q    <= IDLE;
                lane_q     <= '0;
                in_ready_o <= 1'b0;
                busy_o     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (load_start_i) begin
                            state_q    <= FILL;
                            bank_q     <= load_bank_i;
                            last_q     <= load_len_i[SEQ_W-1:0] - 1'b1;
                            word_q     <= '0;
                            lane_q     <= '0;
                            in_ready_o <= 1'b1;
                            busy_o     <= 1'b1;
                        end
                    end
                    FILL: begin
                        if (accept) begin
                            if (lane_full) begin
                                coeff_value_o <= {in_data_i, pack_q};
                                coeff_index_o <= {bank_q, word_q};
                                coeff_write_o <= 1'b1;
                                word_q        <= word_d;
                                lane_q        <= '0;
                                if (word_q == last_q) begin
                                    state_q    <= DONE;
                                    done_o     <= 1'b1;
                                    in_ready_o <= 1'b0;
                                end
                            end else begin
                                pack_q[lane_q*DW +: DW] <= in_data_i;
                                lane_q                  <= lane_d;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end
                    default: begin
                        state_q    <= IDLE;
                        in_ready_o <= 1'b0;
                        busy_o     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_corr_coeff_loader.sv
// tb/tb_corr_coeff_loader.sv - directed self-checking bench for corr_coeff_loader
module tb_corr_coeff_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic [1:0]  load_bank;
    logic [6:0]  load_len;
    logic        load_abort;
    logic [8:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  coeff_index;
    logic [35:0] coeff_value;
    logic        coeff_write;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int k;
    logic v;

    corr_coeff_loader dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .load_start_i (load_start),
        .load_bank_i  (load_bank),
        .load_len_i   (load_len),
        .load_abort_i (load_abort),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .coeff_index_o(coeff_index),
        .coeff_value_o(coeff_value),
        .coeff_write_o(coeff_write),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] smp(input int i);
        return 9'((i * 37 + 5) % 512);
    endfunction

    function automatic logic [35:0] wrd(input int base);
        return {smp(base + 3), smp(base + 2), smp(base + 1), smp(base)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic w, input logic dn,
                           input logic rdy, input logic bsy);
        chk({tag, "_write"}, 64'(coeff_write), 64'(w));
        chk({tag, "_done"},  64'(done),        64'(dn));
        chk({tag, "_ready"}, 64'(in_ready),    64'(rdy));
        chk({tag, "_busy"},  64'(busy),        64'(bsy));
    endtask

    task automatic start(input logic [1:0] bank, input logic [6:0] len);
        load_start = 1'b1;
        load_bank  = bank;
        load_len   = len;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load_start = 1'b0; load_bank = '0; load_len = '0;
        load_abort = 1'b0; in_data = '0; in_valid = 1'b0;
        tick(); tick();
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_index", 64'(coeff_index), 64'h0);
        chk("reset_value", 64'(coeff_value), 64'h0);
        rst_n = 1'b1;
        tick();

        // 1: single word into bank 2
        start(2'd2, 7'd1);
        chk_ctl("t1_start", 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 9'(i + 1);
            tick();
            if (i < 3) chk("t1_nowr", 64'(coeff_write), 64'h0);
        end
        in_valid = 1'b0;
        chk_ctl("t1_last", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t1_index", 64'(coeff_index), 64'h80);
        chk("t1_value", 64'(coeff_value), 64'({9'd4, 9'd3, 9'd2, 9'd1}));
        tick();
        chk_ctl("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // 2: len=0 means 64 words, back-to-back
        start(2'd1, 7'd0);
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_data  = smp(i);
            tick();
            if (i % 4 == 3) begin
                chk("t2_write", 64'(coeff_write), 64'h1);
                chk("t2_index", 64'(coeff_index), 64'(8'h40 + i / 4));
                chk("t2_value", 64'(coeff_value), 64'(wrd(i - 3)));
                chk("t2_done",  64'(done),        64'(i == 255));
                chk("t2_ready", 64'(in_ready),    64'(i != 255));
            end else begin
                chk("t2_nowr", 64'(coeff_write), 64'h0);
            end
        end
        in_valid = 1'b0;
        tick();
        chk_ctl("t2_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: stalls on a 3-word load into bank 3; garbage data while in_valid is low
        start(2'd3, 7'd3);
        k = 0;
        for (int j = 0; j < 40 && k < 12; j++) begin
            v        = (j % 3 != 1);
            in_valid = v;
            in_data  = v ? smp(k) : 9'h1FF;
            tick();
            if (v && (k % 4 == 3)) begin
                chk("t3_write", 64'(coeff_write), 64'h1);
                chk("t3_index", 64'(coeff_index), 64'(8'hC0 + k / 4));
                chk("t3_value", 64'(coeff_value), 64'(wrd(k - 3)));
                chk("t3_done",  64'(done),        64'(k == 11));
            end else begin
                chk("t3_nowr", 64'(coeff_write), 64'h0);
            end
            if (v) k++;
        end
        in_valid = 1'b0;
        chk("t3_count", 64'(k), 64'd12);
        tick();
        chk_ctl("t3_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // 4: abort mid-word after 6 samples
        start(2'd0, 7'd4);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = smp(50 + i);
            tick();
            if (i == 3) begin
                chk("t4_write", 64'(coeff_write), 64'h1);
                chk("t4_index", 64'(coeff_index), 64'h00);
                chk("t4_value", 64'(coeff_value), 64'(wrd(50)));
            end
        end
        in_data    = smp(56);
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        in_valid   = 1'b0;
        chk_ctl("t4_abort", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_ctl("t4_after", 1'b0, 1'b0, 1'b0, 1'b0);
        load_start = 1'b1; load_abort = 1'b1; load_bank = 2'd2; load_len = 7'd1;
        tick();
        load_start = 1'b0; load_abort = 1'b0;
        chk_ctl("t4_abort_wins", 1'b0, 1'b0, 1'b0, 1'b0);
        start(2'd0, 7'd1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = smp(100 + i);
            tick();
        end
        in_valid = 1'b0;
        chk_ctl("t4_reload", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t4_reload_index", 64'(coeff_index), 64'h00);
        chk("t4_reload_value", 64'(coeff_value), 64'(wrd(100)));
        tick();

        // 5: load_start while busy is ignored
        start(2'd0, 7'd2);
        for (int i = 0; i < 8; i++) begin
            in_valid   = 1'b1;
            in_data    = smp(200 + i);
            load_start = (i == 2);
            load_bank  = (i == 2) ? 2'd3 : 2'd0;
            load_len   = (i == 2) ? 7'd1 : 7'd2;
            tick();
            if (i == 3) begin
                chk("t5_w0_index", 64'(coeff_index), 64'h00);
                chk("t5_w0_done",  64'(done),        64'h0);
                chk("t5_w0_write", 64'(coeff_write), 64'h1);
            end
        end
        load_start = 1'b0;
        chk_ctl("t5_last", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_w1_index", 64'(coeff_index), 64'h01);
        chk("t5_w1_value", 64'(coeff_value), 64'(wrd(204)));
        tick();
        chk_ctl("t5_idle0", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_ctl("t5_idle1", 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;

        // 6: reset lands on a 4th-lane accept
        start(2'd1, 7'd2);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = smp(300 + i);
            tick();
        end
        in_data = smp(303);
        rst_n   = 1'b0;
        #1;
        chk_ctl("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_rst_index", 64'(coeff_index), 64'h0);
        chk("t6_rst_value", 64'(coeff_value), 64'h0);
        @(posedge clk);
        #1;
        chk_ctl("t6_rst_edge", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        chk_ctl("t6_released", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
